// File: rtl/ifmaps_reuse_scheduler.sv
// Pops one ifmap vector from the preload FIFO, holds it, and issues it to the MAC
// array once per output filter. Back-to-back pops when the next vector is already queued.
module ifmaps_reuse_scheduler #(
  parameter int unsigned MAC_NUM = 256,
  parameter int unsigned FILT_W  = 10,
  parameter int unsigned VEC_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [FILT_W-1:0]      reuse_count,
  input  logic [VEC_W-1:0]       vector_count,
  input  logic [5*MAC_NUM-1:0]   ifmaps_in,
  input  logic                   fifo_empty,
  output logic                   fifo_read,
  input  logic                   mac_stall,
  output logic [5*MAC_NUM-1:0]   ifmaps_to_mac,
  output logic                   mac_valid,
  output logic [FILT_W-1:0]      filter_idx,
  output logic [VEC_W-1:0]       vec_idx,
  output logic                   last_filter,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned DATA_W = 5 * MAC_NUM;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   hold_q;
  logic [FILT_W-1:0]   filt_q;
  logic [FILT_W-1:0]   r_last_q;
  logic [VEC_W-1:0]    vec_q;
  logic [VEC_W-1:0]    v_last_q;
  logic                mac_valid_q;
  logic                last_q;
  logic                done_q;

  logic                beat_end;
  logic                tile_end;
  logic                pop;

  // Last filter of the current vector issued this cycle, and whether that ends the tile.
  always_comb begin
    beat_end = 1'b0;
    tile_end = 1'b0;
    pop      = 1'b0;
    if ((state_q == RUN) && !mac_stall) begin
      beat_end = (filt_q == r_last_q);
    end
    tile_end = beat_end && (vec_q == v_last_q);
    if (!fifo_empty) begin
      if (state_q == FETCH) begin
        pop = 1'b1;
      end else if (beat_end && !tile_end) begin
        pop = 1'b1;
      end
    end
  end

  // Counts are latched as last-index values (R-1, V-1) so the compares never need R or V
  // themselves and the maximum counts fit without wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      filt_q      <= '0;
      r_last_q    <= '0;
      vec_q       <= '0;
      v_last_q    <= '0;
      mac_valid_q <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            r_last_q <= (reuse_count == '0) ? '0 : reuse_count - FILT_W'(1);
            v_last_q <= vector_count - VEC_W'(1);
            if (vector_count == '0) begin
              state_q <= FINISH;
            end else begin
              vec_q   <= '0;
              state_q <= FETCH;
            end
          end
        end

        FETCH: begin
          if (pop) begin
            hold_q      <= ifmaps_in;
            filt_q      <= '0;
            mac_valid_q <= 1'b1;
            last_q      <= (r_last_q == '0);
            state_q     <= RUN;
          end
        end

        RUN: begin
          if (!mac_stall) begin
            if (filt_q != r_last_q) begin
              filt_q <= filt_q + FILT_W'(1);
              last_q <= ((filt_q + FILT_W'(1)) == r_last_q);
            end else if (tile_end) begin
              mac_valid_q <= 1'b0;
              last_q      <= 1'b0;
              state_q     <= FINISH;
            end else begin
              vec_q <= vec_q + VEC_W'(1);
              if (pop) begin
                hold_q <= ifmaps_in;
                filt_q <= '0;
                last_q <= (r_last_q == '0);
              end else begin
                mac_valid_q <= 1'b0;
                last_q      <= 1'b0;
                state_q     <= FETCH;
              end
            end
          end
        end

        FINISH: begin
          // done is registered off the FINISH cycle, so it coincides with the return to IDLE.
          done_q  <= 1'b1;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fifo_read     = pop;
  assign ifmaps_to_mac = hold_q;
  assign mac_valid     = mac_valid_q;
  assign filter_idx    = filt_q;
  assign vec_idx       = vec_q;
  assign last_filter   = last_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_ifmaps_reuse_scheduler.sv
// Directed cycle-table bench for ifmaps_reuse_scheduler with a queue-based FIFO model,
// plus hand-written reset and random-stall sequences.
module tb_ifmaps_reuse_scheduler;

  localparam int unsigned MAC_NUM = 4;
  localparam int unsigned FW      = 10;
  localparam int unsigned VW      = 16;
  localparam int unsigned DW      = 5 * MAC_NUM;

  localparam logic [DW-1:0] WA = 20'hAAAA1;
  localparam logic [DW-1:0] WB = 20'hBBBB2;
  localparam logic [DW-1:0] WC = 20'hCCCC3;
  localparam logic [DW-1:0] WD = 20'hDDDD4;
  localparam logic [DW-1:0] WE = 20'hEEEE5;
  localparam logic [DW-1:0] WF = 20'hFFFF6;
  localparam logic [DW-1:0] WG = 20'h12345;
  localparam logic [DW-1:0] WH = 20'h6789A;
  localparam logic [DW-1:0] WI = 20'h13579;
  localparam logic [DW-1:0] WJ = 20'h2468A;
  localparam logic [DW-1:0] WK = 20'h0F0F0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [FW-1:0] reuse_count;
  logic [VW-1:0] vector_count;
  logic [DW-1:0] ifmaps_in;
  logic          fifo_empty;
  logic          fifo_read;
  logic          mac_stall;
  logic [DW-1:0] ifmaps_to_mac;
  logic          mac_valid;
  logic [FW-1:0] filter_idx;
  logic [VW-1:0] vec_idx;
  logic          last_filter;
  logic          busy;
  logic          done;

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] q[$];

  typedef struct {
    string         nm;
    logic          st;
    logic [FW-1:0] rc;
    logic [VW-1:0] vc;
    logic          stl;
    logic          psh;
    logic [DW-1:0] pd;
    logic          fr;
    logic          mv;
    logic [FW-1:0] fi;
    logic [VW-1:0] vi;
    logic [DW-1:0] hd;
    logic          lf;
    logic          bz;
    logic          dn;
  } vec_t;

  vec_t vt[$];

  ifmaps_reuse_scheduler #(.MAC_NUM(MAC_NUM), .FILT_W(FW), .VEC_W(VW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reuse_count(reuse_count),
    .vector_count(vector_count), .ifmaps_in(ifmaps_in), .fifo_empty(fifo_empty),
    .fifo_read(fifo_read), .mac_stall(mac_stall), .ifmaps_to_mac(ifmaps_to_mac),
    .mac_valid(mac_valid), .filter_idx(filter_idx), .vec_idx(vec_idx),
    .last_filter(last_filter), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, bit st, int rc, int vc, bit stl, bit psh,
                              logic [DW-1:0] pd, bit fr, bit mv, int fi, int vi,
                              logic [DW-1:0] hd, bit lf, bit bz, bit dn);
    vec_t v;
    v.nm = nm; v.st = st; v.rc = FW'(rc); v.vc = VW'(vc); v.stl = stl;
    v.psh = psh; v.pd = pd; v.fr = fr; v.mv = mv; v.fi = FW'(fi); v.vi = VW'(vi);
    v.hd = hd; v.lf = lf; v.bz = bz; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic upd();
    fifo_empty = (q.size() == 0);
    ifmaps_in  = fifo_empty ? '0 : q[0];
  endtask

  task automatic pop_if(input logic fr);
    if (fr && q.size() > 0) void'(q.pop_front());
    upd();
  endtask

  task automatic apply(input vec_t v);
    logic fr;
    start = v.st; reuse_count = v.rc; vector_count = v.vc; mac_stall = v.stl;
    if (v.psh) q.push_back(v.pd);
    upd();
    @(negedge clk);
    chk({v.nm, ".fifo_read"},   32'(fifo_read),     32'(v.fr));
    chk({v.nm, ".mac_valid"},   32'(mac_valid),     32'(v.mv));
    chk({v.nm, ".filter_idx"},  32'(filter_idx),    32'(v.fi));
    chk({v.nm, ".vec_idx"},     32'(vec_idx),       32'(v.vi));
    chk({v.nm, ".ifmaps"},      32'(ifmaps_to_mac), 32'(v.hd));
    chk({v.nm, ".last_filter"}, 32'(last_filter),   32'(v.lf));
    chk({v.nm, ".busy"},        32'(busy),          32'(v.bz));
    chk({v.nm, ".done"},        32'(done),          32'(v.dn));
    fr = fifo_read;
    @(posedge clk); #1;
    pop_if(fr);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w7[3];
    logic fr;
    int beats, pops;
    bit fin;

    rst_n = 1'b0; start = 1'b0; reuse_count = '0; vector_count = '0; mac_stall = 1'b0;
    upd();

    // name, st rc vc stl psh pd | fr mv fi vi hold lf busy done
    vt.push_back(mk("rst_idle",   0,0,0,0,1,WA, 0,0,0,0,'0,0,0,0));
    vt.push_back(mk("t2_start",   1,3,2,0,1,WB, 0,0,0,0,'0,0,0,0));
    vt.push_back(mk("t2_fetch",   0,0,0,0,0,'0, 1,0,0,0,'0,0,1,0));
    vt.push_back(mk("t2_a0",      0,0,0,0,0,'0, 0,1,0,0,WA,0,1,0));
    vt.push_back(mk("t2_a1",      0,0,0,0,0,'0, 0,1,1,0,WA,0,1,0));
    vt.push_back(mk("t2_a2",      0,0,0,0,0,'0, 1,1,2,0,WA,1,1,0));
    vt.push_back(mk("t2_b0",      0,0,0,0,0,'0, 0,1,0,1,WB,0,1,0));
    vt.push_back(mk("t2_b1",      0,0,0,0,0,'0, 0,1,1,1,WB,0,1,0));
    vt.push_back(mk("t2_b2",      0,0,0,0,1,WC, 0,1,2,1,WB,1,1,0));
    vt.push_back(mk("t2_fin",     0,0,0,0,0,'0, 0,0,2,1,WB,0,1,0));
    vt.push_back(mk("t2_done",    0,0,0,0,0,'0, 0,0,2,1,WB,0,0,1));
    vt.push_back(mk("t2_idle",    0,0,0,0,0,'0, 0,0,2,1,WB,0,0,0));
    vt.push_back(mk("t3_start",   1,2,2,0,0,'0, 0,0,2,1,WB,0,0,0));
    vt.push_back(mk("t3_fetch",   0,0,0,0,0,'0, 1,0,2,0,WB,0,1,0));
    vt.push_back(mk("t3_c0",      0,0,0,0,0,'0, 0,1,0,0,WC,0,1,0));
    vt.push_back(mk("t3_c1",      0,0,0,0,0,'0, 0,1,1,0,WC,1,1,0));
    vt.push_back(mk("t3_wait1",   0,0,0,0,0,'0, 0,0,1,1,WC,0,1,0));
    vt.push_back(mk("t3_wait2",   0,0,0,0,0,'0, 0,0,1,1,WC,0,1,0));
    vt.push_back(mk("t3_wait3",   0,0,0,0,0,'0, 0,0,1,1,WC,0,1,0));
    vt.push_back(mk("t3_arrive",  0,0,0,0,1,WD, 1,0,1,1,WC,0,1,0));
    vt.push_back(mk("t3_d0",      0,0,0,0,0,'0, 0,1,0,1,WD,0,1,0));
    vt.push_back(mk("t3_d1",      0,0,0,0,0,'0, 0,1,1,1,WD,1,1,0));
    vt.push_back(mk("t3_fin",     0,0,0,0,0,'0, 0,0,1,1,WD,0,1,0));
    vt.push_back(mk("t3_done",    0,0,0,0,0,'0, 0,0,1,1,WD,0,0,1));
    vt.push_back(mk("t4_start",   1,4,1,0,1,WE, 0,0,1,1,WD,0,0,0));
    vt.push_back(mk("t4_fetch",   0,0,0,0,0,'0, 1,0,1,0,WD,0,1,0));
    vt.push_back(mk("t4_e0",      0,0,0,0,0,'0, 0,1,0,0,WE,0,1,0));
    vt.push_back(mk("t4_stall1",  0,0,0,1,1,WF, 0,1,1,0,WE,0,1,0));
    vt.push_back(mk("t4_stall2",  0,0,0,1,0,'0, 0,1,1,0,WE,0,1,0));
    vt.push_back(mk("t4_stall3",  0,0,0,1,0,'0, 0,1,1,0,WE,0,1,0));
    vt.push_back(mk("t4_e1",      0,0,0,0,0,'0, 0,1,1,0,WE,0,1,0));
    vt.push_back(mk("t4_e2",      0,0,0,0,0,'0, 0,1,2,0,WE,0,1,0));
    vt.push_back(mk("t4_e3",      0,0,0,0,0,'0, 0,1,3,0,WE,1,1,0));
    vt.push_back(mk("t4_fin",     0,0,0,0,0,'0, 0,0,3,0,WE,0,1,0));
    vt.push_back(mk("t4_done",    0,0,0,0,0,'0, 0,0,3,0,WE,0,0,1));
    vt.push_back(mk("t5_v0",      1,5,0,0,0,'0, 0,0,3,0,WE,0,0,0));
    vt.push_back(mk("t5_v0_fin",  0,0,0,0,0,'0, 0,0,3,0,WE,0,1,0));
    vt.push_back(mk("t5_v0_done", 0,0,0,0,0,'0, 0,0,3,0,WE,0,0,1));
    vt.push_back(mk("t5_r0",      1,0,1,0,0,'0, 0,0,3,0,WE,0,0,0));
    vt.push_back(mk("t5_r0_fetch",0,0,0,0,0,'0, 1,0,3,0,WE,0,1,0));
    vt.push_back(mk("t5_r0_f0",   0,0,0,0,0,'0, 0,1,0,0,WF,1,1,0));
    vt.push_back(mk("t5_r0_fin",  0,0,0,0,0,'0, 0,0,0,0,WF,0,1,0));
    vt.push_back(mk("t5_r0_done", 0,0,0,0,0,'0, 0,0,0,0,WF,0,0,1));
    vt.push_back(mk("t6_start",   1,2,2,0,1,WG, 0,0,0,0,WF,0,0,0));
    vt.push_back(mk("t6_restart", 1,7,9,0,1,WH, 1,0,0,0,WF,0,1,0));
    vt.push_back(mk("t6_g0",      1,1,1,0,0,'0, 0,1,0,0,WG,0,1,0));
    vt.push_back(mk("t6_g1",      0,3,5,0,0,'0, 1,1,1,0,WG,1,1,0));
    vt.push_back(mk("t6_h0",      0,3,5,0,0,'0, 0,1,0,1,WH,0,1,0));
    vt.push_back(mk("t6_h1",      0,3,5,0,0,'0, 0,1,1,1,WH,1,1,0));
    vt.push_back(mk("t6_fin",     0,3,5,0,0,'0, 0,0,1,1,WH,0,1,0));
    vt.push_back(mk("t6_done",    0,3,5,0,0,'0, 0,0,1,1,WH,0,0,1));
    vt.push_back(mk("t1_start",   1,3,1,0,1,WI, 0,0,1,1,WH,0,0,0));
    vt.push_back(mk("t1_fetch",   0,0,0,0,0,'0, 1,0,1,0,WH,0,1,0));
    vt.push_back(mk("t1_i0",      0,0,0,0,0,'0, 0,1,0,0,WI,0,1,0));

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) apply(vt[i]);

    // Asynchronous reset in the middle of RUN, with a word waiting in the FIFO.
    q.push_back(WJ); upd();
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst.fifo_read",   32'(fifo_read),     32'h0);
    chk("t1_rst.mac_valid",   32'(mac_valid),     32'h0);
    chk("t1_rst.filter_idx",  32'(filter_idx),    32'h0);
    chk("t1_rst.vec_idx",     32'(vec_idx),       32'h0);
    chk("t1_rst.ifmaps",      32'(ifmaps_to_mac), 32'h0);
    chk("t1_rst.last_filter", 32'(last_filter),   32'h0);
    chk("t1_rst.busy",        32'(busy),          32'h0);
    chk("t1_rst.done",        32'(done),          32'h0);
    q.delete(); upd();
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.push_back(WK); upd();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t1_post.fifo_read", 32'(fifo_read), 32'h0);
      chk("t1_post.busy",      32'(busy),      32'h0);
      chk("t1_post.mac_valid", 32'(mac_valid), 32'h0);
      @(posedge clk); #1;
    end

    // Full tile R=2, V=3 under random stalls; every issued beat checked against a model.
    w7[0] = WK; w7[1] = WA; w7[2] = WB;
    q.push_back(WA); q.push_back(WB); upd();
    start = 1'b1; reuse_count = FW'(2); vector_count = VW'(3); mac_stall = 1'b0;
    beats = 0; pops = 0; fin = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      if (mac_valid && !mac_stall) begin
        if (beats < 6) begin
          chk("t7_beat.ifmaps",     32'(ifmaps_to_mac), 32'(w7[beats/2]));
          chk("t7_beat.filter_idx", 32'(filter_idx),    32'(beats % 2));
          chk("t7_beat.vec_idx",    32'(vec_idx),       32'(beats / 2));
        end
        beats++;
      end
      if (fifo_read) begin
        chk("t7_pop_nonempty", 32'(fifo_empty), 32'h0);
        pops++;
      end
      if (done) fin = 1'b1;
      fr = fifo_read;
      @(posedge clk); #1;
      start = 1'b0; reuse_count = '0; vector_count = '0;
      pop_if(fr);
      mac_stall = ($urandom_range(0, 3) == 0);
    end
    mac_stall = 1'b0;
    chk("t7_done_seen", 32'(fin),   32'h1);
    chk("t7_pops",      32'(pops),  32'd3);
    chk("t7_beats",     32'(beats), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
